// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg
//   Shared types and default parameter values for the UART threshold FIFO.
//   - req_state_e : state of the level-to-pulse request detector
//   - DEF_*       : default parameter values used by uart_thresh_fifo
package uart_fifo_pkg;

    // IDLE  : the request level was low on the previous clock
    // CHECK : the request level was high on the previous clock
    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } req_state_e;

    localparam int DEF_DATA_SIZE = 8;
    localparam int DEF_SIZE_FIFO = 16;
    localparam int DEF_AE_LEVEL  = 2;
    localparam int DEF_EDGE_MODE = 1;

endpackage

// File: rtl/uart_req_pulse.sv
// uart_req_pulse
//   Turns a request level into a single-cycle pulse on its rising edge.
//   With EDGE_MODE = 0 the request passes through unchanged.
//   Ports:
//     clk      in  clock
//     reset_n  in  asynchronous active-low reset
//     req_i    in  raw request (level or strobe)
//     pulse_o  out effective request, same cycle as the rising level
module uart_req_pulse
    import uart_fifo_pkg::*;
#(
    parameter int EDGE_MODE = DEF_EDGE_MODE
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req_i,
    output logic pulse_o
);

    req_state_e state_q;
    req_state_e state_d;

    // The detector always follows the raw level, including while the FIFO is
    // being flushed, so a level held across a flush cannot fire again later.
    assign state_d = req_i ? CHECK : IDLE;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign pulse_o = (EDGE_MODE != 0) ? (req_i && (state_q == IDLE)) : req_i;

endmodule

// File: rtl/uart_thresh_fifo.sv
// uart_thresh_fifo
//   Synchronous show-ahead FIFO with registered full/empty/threshold status,
//   registered occupancy count and sticky overflow/underflow flags.
//   Ports:
//     clk, reset_n              clock, asynchronous active-low reset
//     flush                     synchronous empty request (beats write/read)
//     clr_err                   synchronous clear of overflow/underflow
//     data_in, write, read      write data and requests (see EDGE_MODE)
//     data_out                  head word, valid combinationally
//     full, empty               registered status
//     almost_full, almost_empty registered threshold status
//     count                     registered occupancy, 0..SIZE_FIFO
//     overflow, underflow       sticky error flags
module uart_thresh_fifo
    import uart_fifo_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int SIZE_FIFO = DEF_SIZE_FIFO,
    parameter int AF_LEVEL  = SIZE_FIFO - 2,
    parameter int AE_LEVEL  = DEF_AE_LEVEL,
    parameter int EDGE_MODE = DEF_EDGE_MODE
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       clr_err,
    input  logic [DATA_SIZE-1:0]       data_in,
    input  logic                       write,
    input  logic                       read,
    output logic [DATA_SIZE-1:0]       data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(SIZE_FIFO):0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = $clog2(SIZE_FIFO);
    localparam int CNT_W = PTR_W + 1;

    logic                 wr_pulse, rd_pulse;
    logic                 wr_acc, rd_acc, mem_we;
    logic [DATA_SIZE-1:0] mem_q [SIZE_FIFO];
    logic [PTR_W-1:0]     ptr_wr_q, ptr_wr_d, ptr_rd_q, ptr_rd_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 full_q, empty_q, af_q, ae_q;
    logic                 overflow_q, overflow_d, underflow_q, underflow_d;

    uart_req_pulse #(.EDGE_MODE(EDGE_MODE)) u_wr_pulse (
        .clk     (clk),
        .reset_n (reset_n),
        .req_i   (write),
        .pulse_o (wr_pulse)
    );

    uart_req_pulse #(.EDGE_MODE(EDGE_MODE)) u_rd_pulse (
        .clk     (clk),
        .reset_n (reset_n),
        .req_i   (read),
        .pulse_o (rd_pulse)
    );

    // A read frees the slot a same-cycle write needs, so a full FIFO still
    // accepts a write alongside a read. An empty FIFO never accepts a read,
    // even with a same-cycle write: the head word is not there yet.
    assign rd_acc = rd_pulse && !empty_q;
    assign wr_acc = wr_pulse && (!full_q || rd_acc);
    assign mem_we = wr_acc && !flush;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        ptr_wr_d = ptr_wr_q;
        ptr_rd_d = ptr_rd_q;
        count_d  = count_q;
        if (flush) begin
            ptr_wr_d = '0;
            ptr_rd_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) ptr_wr_d = ptr_wr_q + 1'b1;
            if (rd_acc) ptr_rd_d = ptr_rd_q + 1'b1;
            count_d = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        end
    end

    // A new error in the same cycle as clr_err keeps its flag set.
    // Flush drops the requests, so it raises no error either.
    always_comb begin
        overflow_d  = overflow_q && !clr_err;
        underflow_d = underflow_q && !clr_err;
        if (!flush && wr_pulse && full_q && !rd_acc) overflow_d  = 1'b1;
        if (!flush && rd_pulse && empty_q)           underflow_d = 1'b1;
    end

    // Status flags are computed from the next count so they change on the
    // same edge as the operation that moves the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_wr_q    <= '0;
            ptr_rd_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            ptr_wr_q    <= ptr_wr_d;
            ptr_rd_q    <= ptr_rd_d;
            count_q     <= count_d;
            full_q      <= (count_d == CNT_W'(SIZE_FIFO));
            empty_q     <= (count_d == '0);
            af_q        <= (count_d >= CNT_W'(AF_LEVEL));
            ae_q        <= (count_d <= CNT_W'(AE_LEVEL));
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: the storage array is reset on purpose so data_out reads zero
    // after reset; this forces flops rather than a RAM macro.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SIZE_FIFO; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[ptr_wr_q] <= data_in;
        end
    end

    assign data_out     = mem_q[ptr_rd_q];
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_uart_thresh_fifo.sv
// tb_uart_thresh_fifo
//   Self-checking bench for uart_thresh_fifo (depth 8, AF 6, AE 2, edge mode).
//   A queue-based model tracks contents and sticky flags; a compare process
//   checks every output on every falling edge, and directed scenarios pin the
//   model with literal expectations before a randomized phase.
module tb_uart_thresh_fifo;

    localparam int DW = 8;
    localparam int DEPTH = 8;
    localparam int AF = 6;
    localparam int AE = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          flush = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          write = 1'b0;
    logic          read = 1'b0;
    logic [DW-1:0] data_out;
    logic          full, empty, almost_full, almost_empty;
    logic [3:0]    count;
    logic          overflow, underflow;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    uart_thresh_fifo #(
        .DATA_SIZE (DW),
        .SIZE_FIFO (DEPTH),
        .AF_LEVEL  (AF),
        .AE_LEVEL  (AE),
        .EDGE_MODE (1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .clr_err      (clr_err),
        .data_in      (data_in),
        .write        (write),
        .read         (read),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: contents as a queue, rising-edge detection from the
    // previous sampled level, sticky flags.
    logic [DW-1:0] m_q[$];
    bit m_wprev = 0, m_rprev = 0, m_ovf = 0, m_unf = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_wprev = 0;
            m_rprev = 0;
            m_ovf   = 0;
            m_unf   = 0;
        end else begin
            bit wp, rp, do_rd, do_wr, e_ovf, e_unf;
            int n;
            wp = write && !m_wprev;
            rp = read && !m_rprev;
            m_wprev = write;
            m_rprev = read;
            e_ovf = 0;
            e_unf = 0;
            if (flush) begin
                m_q.delete();
            end else begin
                n = m_q.size();
                do_rd = rp && (n > 0);
                do_wr = wp && ((n < DEPTH) || do_rd);
                e_ovf = wp && (n == DEPTH) && !do_rd;
                e_unf = rp && (n == 0);
                if (do_rd) void'(m_q.pop_front());
                if (do_wr) m_q.push_back(data_in);
            end
            m_ovf = e_ovf || (m_ovf && !clr_err);
            m_unf = e_unf || (m_unf && !clr_err);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int n;
            n = m_q.size();
            check("count", 32'(count), 32'(n));
            check("full", 32'(full), 32'(n == DEPTH));
            check("empty", 32'(empty), 32'(n == 0));
            check("almost_full", 32'(almost_full), 32'(n >= AF));
            check("almost_empty", 32'(almost_empty), 32'(n <= AE));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("underflow", 32'(underflow), 32'(m_unf));
            if (n > 0) check("data_out", 32'(data_out), 32'(m_q[0]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr_pulse(input logic [DW-1:0] d);
        data_in = d;
        write = 1'b1;
        tick();
        write = 1'b0;
        tick();
    endtask

    task automatic rd_pulse();
        read = 1'b1;
        tick();
        read = 1'b0;
        tick();
    endtask

    task automatic both_pulse(input logic [DW-1:0] d);
        data_in = d;
        write = 1'b1;
        read = 1'b1;
        tick();
        write = 1'b0;
        read = 1'b0;
        tick();
    endtask

    task automatic clear_errors();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        tick();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) rd_pulse();
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #1 chk_en = 1'b1;
        #10;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_ae", 32'(almost_empty), 1);
        check("rst_data_out", 32'(data_out), 0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        tick();

        // Fill to full, almost_full from count 6, then overflow.
        for (int i = 0; i < DEPTH; i++) begin
            wr_pulse(DW'(8'h11 + i));
            check("fill_af", 32'(almost_full), 32'((i + 1) >= AF));
        end
        check("fill_count", 32'(count), 8);
        check("fill_full", 32'(full), 1);
        wr_pulse(8'h99);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_count", 32'(count), 8);
        check("ovf_head", 32'(data_out), 32'h11);

        // Drain in order, almost_empty at count <= 2, then underflow.
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_head", 32'(data_out), 32'(8'h11 + i));
            rd_pulse();
            check("drain_ae", 32'(almost_empty), 32'((DEPTH - 1 - i) <= AE));
        end
        check("drain_empty", 32'(empty), 1);
        rd_pulse();
        check("unf_flag", 32'(underflow), 1);
        clear_errors();
        check("clr_ovf", 32'(overflow), 0);
        check("clr_unf", 32'(underflow), 0);

        // A held write level writes exactly once.
        data_in = 8'hA5;
        write = 1'b1;
        repeat (5) tick();
        write = 1'b0;
        tick();
        check("hold_count", 32'(count), 1);
        check("hold_data", 32'(data_out), 32'hA5);
        drain(1);

        // Simultaneous write and read at count 3 and at count 0.
        wr_pulse(8'h01);
        wr_pulse(8'h02);
        wr_pulse(8'h03);
        both_pulse(8'h04);
        check("both3_count", 32'(count), 3);
        check("both3_head", 32'(data_out), 32'h02);
        drain(3);
        both_pulse(8'h77);
        check("both0_count", 32'(count), 1);
        check("both0_unf", 32'(underflow), 1);
        check("both0_head", 32'(data_out), 32'h77);
        drain(1);
        clear_errors();

        // Pointer wrap: write 5, read 3, write 6.
        for (int i = 0; i < 5; i++) wr_pulse(DW'(8'h21 + i));
        check("wrap_c5", 32'(count), 5);
        for (int i = 0; i < 3; i++) begin
            check("wrap_rd", 32'(data_out), 32'(8'h21 + i));
            rd_pulse();
        end
        check("wrap_c2", 32'(count), 2);
        for (int i = 0; i < 6; i++) wr_pulse(DW'(8'h31 + i));
        check("wrap_c8", 32'(count), 8);
        check("wrap_full", 32'(full), 1);
        // Full with simultaneous read and write: both accepted.
        both_pulse(8'h3F);
        check("both8_full", 32'(full), 1);
        check("both8_head", 32'(data_out), 32'h25);
        drain(8);

        // Flush beats a same-cycle write; a level held through flush does
        // not fire afterwards.
        for (int i = 0; i < 4; i++) wr_pulse(DW'(8'h41 + i));
        flush = 1'b1;
        write = 1'b1;
        data_in = 8'hEE;
        tick();
        flush = 1'b0;
        tick();
        tick();
        check("flush_count", 32'(count), 0);
        check("flush_empty", 32'(empty), 1);
        write = 1'b0;
        tick();

        // Asynchronous reset mid-fill with a sticky flag set.
        rd_pulse();
        for (int i = 0; i < 3; i++) wr_pulse(DW'(8'h51 + i));
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("arst_count", 32'(count), 0);
        check("arst_empty", 32'(empty), 1);
        check("arst_full", 32'(full), 0);
        check("arst_ae", 32'(almost_empty), 1);
        check("arst_af", 32'(almost_full), 0);
        check("arst_unf", 32'(underflow), 0);
        check("arst_ovf", 32'(overflow), 0);
        check("arst_data", 32'(data_out), 0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        tick();

        // Randomized phase, alternating write-heavy and read-heavy segments.
        for (int seg = 0; seg < 8; seg++) begin
            for (int c = 0; c < 400; c++) begin
                int wprob;
                wprob = (seg % 2 == 0) ? 75 : 30;
                write   = ($urandom_range(0, 99) < wprob);
                read    = ($urandom_range(0, 99) < (100 - wprob));
                data_in = DW'($urandom);
                flush   = ($urandom_range(0, 99) == 0);
                clr_err = ($urandom_range(0, 31) == 0);
                tick();
            end
        end
        write = 1'b0;
        read = 1'b0;
        flush = 1'b0;
        clr_err = 1'b0;
        tick();
        tick();
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
